uart_transmit: RTL and testbench

UART_TRANSMIT -- requirements
Module: uart_transmit

---
 rtl/uart_transmit_if.sv | 18 +
 rtl/uart_transmit.sv | 79 +++++++
 tb/tb_uart_transmit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/uart_transmit_if.sv
// uart_transmit_if: write port and serial/status outputs of the FIFO-buffered UART transmitter
interface uart_transmit_if;
  logic       i_DataValid;
  logic [7:0] i_Tx_Byte;
  logic       o_Ready;
  logic       o_Overflow;
  logic       o_Tx_Serial;
  logic       o_Active;
  logic       o_Done;
  modport master (
    output i_DataValid, i_Tx_Byte,
    input  o_Ready, o_Overflow, o_Tx_Serial, o_Active, o_Done
  );
  modport slave (
    input  i_DataValid, i_Tx_Byte,
    output o_Ready, o_Overflow, o_Tx_Serial, o_Active, o_Done
  );
endinterface

// File: rtl/uart_transmit.sv
// uart_transmit: 8N1 UART transmitter fed by a small write FIFO
module uart_transmit #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  uart_transmit_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        r_state, w_state_nx;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count, w_count_nx;
  logic [BW-1:0] r_baud, w_baud_nx;
  logic [2:0]    r_bit, w_bit_nx;
  logic [7:0]    r_shift, w_shift_nx;
  logic          r_ready, r_overflow, r_tx, w_tx_nx, w_push, w_pop, w_last;
  // Acceptance uses the registered ready, so a pop in the same cycle never frees a full FIFO early.
  assign w_push     = bus.i_DataValid & r_ready;
  assign w_pop      = (r_state == IDLE) && (r_count != '0);
  assign w_count_nx = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_last     = r_baud == BW'(CLKS_PER_BIT - 1);
  always_ff @(posedge i_CLK)
    if (w_push) r_mem[r_wr_ptr] <= bus.i_Tx_Byte;
  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit;
    w_shift_nx = r_shift;
    w_baud_nx  = (r_state == IDLE || w_last) ? '0 : r_baud + BW'(1);
    case (r_state)
      IDLE:  if (w_pop) begin
               w_state_nx = START;
               w_shift_nx = r_mem[r_rd_ptr];
             end
      START: if (w_last) begin
               w_state_nx = DATA;
               w_bit_nx   = '0;
             end
      DATA:  if (w_last) begin
               w_bit_nx = r_bit + 3'd1;
               if (r_bit == 3'd7) w_state_nx = STOP;
             end
      STOP:  if (w_last) w_state_nx = IDLE;
    endcase
    w_tx_nx = w_state_nx == START ? 1'b0 : w_state_nx == DATA ? w_shift_nx[w_bit_nx] : 1'b1;
  end
  always_ff @(posedge i_CLK or negedge i_RST_N)
    if (!i_RST_N) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud     <= w_baud_nx;
      r_bit      <= w_bit_nx;
      r_shift    <= w_shift_nx;
      r_tx       <= w_tx_nx;
      r_wr_ptr   <= r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= r_rd_ptr + AW'(w_pop);
      r_count    <= w_count_nx;
      r_ready    <= w_count_nx != (AW+1)'(FIFO_DEPTH);
      r_overflow <= bus.i_DataValid & ~r_ready;
    end
  assign bus.o_Ready     = r_ready;
  assign bus.o_Overflow  = r_overflow;
  assign bus.o_Tx_Serial = r_tx;
  assign bus.o_Active    = r_state != IDLE;
  assign bus.o_Done      = (r_state == STOP) && w_last;
endmodule

// File: tb/tb_uart_transmit.sv
// tb_uart_transmit: random and directed stimulus against a frame-timeline reference model
module tb_uart_transmit;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, failures = 0;
  int ovf_seen = 0, done_seen = 0;
  logic [7:0] q[$];
  int phase = -1;
  logic [9:0] frame = '1;
  logic exp_ovf = 1'b0;
  uart_transmit_if bus();
  uart_transmit_if bus2();
  uart_transmit #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.i_CLK(clk), .i_RST_N(rst_n), .bus(bus));
  uart_transmit #(.CLKS_PER_BIT(217), .FIFO_DEPTH(4)) dut2 (.i_CLK(clk), .i_RST_N(rst_n), .bus(bus2));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    phase = -1;
    exp_ovf = 1'b0;
  endtask
  // Predicts the state after the coming rising edge: a frame is a 10-bit timeline of CPB cycles per bit.
  task automatic model_step(logic v, logic [7:0] d);
    logic rdy;
    rdy = q.size() < DEPTH;
    exp_ovf = v && !rdy;
    if (phase >= 0) begin
      phase++;
      if (phase == 10 * CPB) phase = -1;
    end else if (q.size() > 0) begin
      frame = {1'b1, q.pop_front(), 1'b0};
      phase = 0;
    end
    if (v && rdy) q.push_back(d);
  endtask
  task automatic compare();
    check("tx", bus.o_Tx_Serial, phase < 0 ? 1'b1 : frame[phase / CPB]);
    check("active", bus.o_Active, phase >= 0);
    check("done", bus.o_Done, phase == 10 * CPB - 1);
    check("ready", bus.o_Ready, q.size() < DEPTH);
    check("overflow", bus.o_Overflow, exp_ovf);
    if (bus.o_Overflow) ovf_seen++;
    if (bus.o_Done) done_seen++;
  endtask
  task automatic tick(logic v, logic [7:0] d);
    compare();
    bus.i_DataValid = v;
    bus.i_Tx_Byte = d;
    if (rst_n) model_step(v, d);
    else model_reset();
    @(negedge clk);
  endtask
  initial begin
    int d0, o0, n, first_low, first_high, lows, dones, done_k;
    logic [7:0] burst [6];
    burst = '{8'h69, 8'h6B, 8'h73, 8'h77, 8'h00, 8'h55};
    bus.i_DataValid = 1'b0;
    bus.i_Tx_Byte = '0;
    bus2.i_DataValid = 1'b0;
    bus2.i_Tx_Byte = '0;
    model_reset();
    @(negedge clk);
    repeat (3) tick(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (5) tick(1'b0, 8'h00);
    d0 = done_seen;
    tick(1'b1, 8'h77);
    repeat (45) tick(1'b0, 8'h00);
    check("single_done_count", done_seen - d0, 1);
    d0 = done_seen;
    o0 = ovf_seen;
    for (int i = 0; i < 6; i++) tick(1'b1, burst[i]);
    repeat (5 * (10 * CPB + 1) + 10) tick(1'b0, 8'h00);
    check("burst_ovf_count", ovf_seen - o0, 1);
    check("burst_done_count", done_seen - d0, 5);
    tick(1'b1, 8'h6B);
    repeat (15) tick(1'b0, 8'h00);
    tick(1'b1, 8'h73);
    repeat (90) tick(1'b0, 8'h00);
    tick(1'b1, 8'hA5);
    tick(1'b1, 8'h3C);
    tick(1'b1, 8'hC3);
    n = 0;
    while (!(phase >= 0 && phase / CPB == 4) && n < 100) begin
      tick(1'b0, 8'h00);
      n++;
    end
    check("reach_bit3", n < 100, 1);
    d0 = done_seen;
    rst_n = 1'b0;
    #1;
    check("rst_tx_now", bus.o_Tx_Serial, 1'b1);
    check("rst_active_now", bus.o_Active, 1'b0);
    check("rst_ready_now", bus.o_Ready, 1'b1);
    model_reset();
    @(negedge clk);
    repeat (2) tick(1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (60) tick(1'b0, 8'h00);
    check("rst_no_done", done_seen - d0, 0);
    repeat (3000) tick($urandom_range(0, 5) == 0, 8'($urandom));
    repeat (500) tick(1'($urandom_range(0, 1)), 8'($urandom));
    repeat (5 * (10 * CPB + 1) + 5) tick(1'b0, 8'h00);
    bus2.i_DataValid = 1'b1;
    bus2.i_Tx_Byte = 8'h00;
    @(negedge clk);
    bus2.i_DataValid = 1'b0;
    first_low = -1;
    first_high = -1;
    lows = 0;
    dones = 0;
    done_k = -1;
    for (int k = 1; k <= 2300; k++) begin
      @(negedge clk);
      if (bus2.o_Tx_Serial == 1'b0) begin
        lows++;
        if (first_low < 0) first_low = k;
      end else if (first_low >= 0 && first_high < 0) first_high = k;
      if (bus2.o_Done) begin
        dones++;
        done_k = k;
      end
    end
    check("slow_first_low", first_low, 1);
    check("slow_low_count", lows, 1953);
    check("slow_low_run", first_high - first_low, 1953);
    check("slow_done_cycle", done_k - first_low + 1, 2170);
    check("slow_done_count", dones, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
